peak_finder: RTL
================

PEAK_FINDER -- requirements
Module: peak_finder

Interface
REQ-001 Parameter NB, 4, histogram bin-index width; BINS = 2**NB bins per pixel.
REQ-002 Parameter NPIX_W, 1, pixel-index width; PIXELS = 2**NPIX_W pixels per RAM.
REQ-003 Parameter CNT_W, 8, bin count width (matches histogram RAM data width).
REQ-004 Parameter WIN, 2, half-width in bins of the TH-/TH+ filter window.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 res  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; begins a scan of all pixels.
REQ-008 counts  in  CNT_W  histogram RAM read-port data, valid 1 cycle after raddr.
REQ-009 raddr  out  NPIX_W+NB  read address = {pixel, bin}.
REQ-010 rEnable  out  1  RAM port-b enable, active low (0 = read).
REQ-011 readFlag  out  1  RAM port-b memory enable (meb), active high.
REQ-012 busy  out  1  high from the cycle after accepted start until done.
REQ-013 peak_valid  out  1  one-cycle strobe; peak_* and th_* valid this cycle only.
REQ-014 peak_pixel  out  NPIX_W  pixel index of the result.
REQ-015 peak_bin  out  NB  bin index of the maximum count.
REQ-016 peak_count  out  CNT_W  maximum count value.
REQ-017 th_minus, th_plus  out  NB each  filter window bounds.
REQ-018 done  out  1  one-cycle pulse after the last pixel's peak_valid.

Function
REQ-019 States: IDLE, READ, DRAIN, EMIT, DONE.
REQ-020 IDLE: start=1 -> READ, pixel=0, bin=0; start ignored in all other states.
REQ-021 READ: each cycle raddr={pixel,bin}, rEnable=0, readFlag=1, bin increments; after bin=BINS-1 is issued -> DRAIN.
REQ-022 DRAIN: rEnable=1, readFlag=0; compares the final returned count -> EMIT.
REQ-023 Compare each returned count with running max using strict greater-than; equal counts keep the lower bin.
REQ-024 Running max and index clear to 0/0 at first read of each pixel; all-zero histogram yields peak_bin=0, peak_count=0.
REQ-025 EMIT: peak_valid=1 with results; if pixel=PIXELS-1 -> DONE, else pixel+1, bin=0, -> READ.
REQ-026 DONE: done=1 for one cycle -> IDLE.
REQ-027 th_minus = peak_bin-WIN saturated at 0; th_plus = peak_bin+WIN saturated at BINS-1; computed at NB+1 bits internally.
REQ-028 Latency: start at cycle 0 -> first raddr cycle 1; pixel p's peak_valid at cycle (p+1)*(BINS+2); done one cycle after the last peak_valid.
REQ-029 Outputs other than peak_valid/done hold their last values between strobes.

Reset
REQ-030 res=1 at any clock edge, including mid-scan, aborts the scan -> IDLE on the next cycle.
REQ-031 Reset values: raddr=0, rEnable=1, readFlag=0, busy=0, peak_valid=0, done=0, all peak_*/th_*=0.
REQ-032 start coincident with res is ignored.

Structure
REQ-033 NB, NPIX_W, CNT_W, WIN defaults and the state encoding go in the shared SiFH parameters header.
REQ-034 Single module; optional sub-module peak_window computing th_minus/th_plus combinationally.

Verification
REQ-035 NB=4, NPIX_W=1; pixel0 bin5=9, others 1 -> pixel0 peak_bin=5, count=9, th_minus=3, th_plus=7, peak_valid at cycle 18.
REQ-036 Tie: pixel1 bins 3 and 11 both =7 -> peak_bin=3, count=7; done at cycle 37.
REQ-037 Edge saturation: peak at bin 0 -> th_minus=0, th_plus=2; peak at bin 15 -> th_minus=13, th_plus=15.
REQ-038 All-zero histogram -> peak_bin=0, peak_count=0, peak_valid still strobes.
REQ-039 res=1 at cycle 8 of a scan -> next cycle busy=0, rEnable=1, readFlag=0; no peak_valid or done until a new start.
REQ-040 start pulsed while busy -> ignored; exactly PIXELS peak_valid strobes and one done.

Source files
------------

// File: rtl/peak_finder_pkg.sv
// Shared parameter defaults and state encoding for the histogram peak finder.
package peak_finder_pkg;

    localparam int NB_DEF     = 4;
    localparam int NPIX_W_DEF = 1;
    localparam int CNT_W_DEF  = 8;
    localparam int WIN_DEF    = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/peak_finder_window.sv
// Filter window bounds around a peak bin, saturated to the valid bin range.
module peak_finder_window
    import peak_finder_pkg::*;
#(
    parameter int NB  = NB_DEF,
    parameter int WIN = WIN_DEF
) (
    input  logic [NB-1:0] bin,
    output logic [NB-1:0] th_minus,
    output logic [NB-1:0] th_plus
);

    localparam logic [NB:0] WIN_X = (NB+1)'(WIN);
    localparam logic [NB:0] MAX_X = (NB+1)'(2**NB - 1);

    logic [NB:0] bin_x;
    logic [NB:0] lo_x;
    logic [NB:0] hi_x;

    // One extra bit keeps the +WIN sum from wrapping before the clamp.
    always_comb begin
        bin_x = {1'b0, bin};
        lo_x  = (bin_x < WIN_X) ? '0 : (bin_x - WIN_X);
        hi_x  = bin_x + WIN_X;
        if (hi_x > MAX_X) begin
            hi_x = MAX_X;
        end
        th_minus = NB'(lo_x);
        th_plus  = NB'(hi_x);
    end

endmodule

// File: rtl/peak_finder.sv
// Scans every pixel's histogram in RAM and reports the bin with the maximum count
// plus a saturated filter window around it.
module peak_finder
    import peak_finder_pkg::*;
#(
    parameter int NB     = NB_DEF,
    parameter int NPIX_W = NPIX_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WIN    = WIN_DEF
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [CNT_W-1:0]     counts,
    output logic [NPIX_W+NB-1:0] raddr,
    output logic                 rEnable,
    output logic                 readFlag,
    output logic                 busy,
    output logic                 peak_valid,
    output logic [NPIX_W-1:0]    peak_pixel,
    output logic [NB-1:0]        peak_bin,
    output logic [CNT_W-1:0]     peak_count,
    output logic [NB-1:0]        th_minus,
    output logic [NB-1:0]        th_plus,
    output logic                 done
);

    localparam logic [NB-1:0]     LAST_BIN = NB'(2**NB - 1);
    localparam logic [NPIX_W-1:0] LAST_PIX = NPIX_W'(2**NPIX_W - 1);

    state_t              state_q, state_d;
    logic [NPIX_W-1:0]   pixel_q, pixel_d;
    logic [NB-1:0]       bin_q, bin_d;
    logic                rd_valid_q, rd_valid_d;
    logic [NB-1:0]       rd_bin_q, rd_bin_d;
    logic [CNT_W-1:0]    max_q, max_d;
    logic [NB-1:0]       idx_q, idx_d;
    logic [NPIX_W-1:0]   peak_pixel_q, peak_pixel_d;
    logic [NB-1:0]       peak_bin_q, peak_bin_d;
    logic [CNT_W-1:0]    peak_count_q, peak_count_d;
    logic [NB-1:0]       th_minus_q, th_minus_d;
    logic [NB-1:0]       th_plus_q, th_plus_d;
    logic [CNT_W-1:0]    cmp_base;
    logic [NB-1:0]       win_minus, win_plus;

    // Count for bin 0 compares against zero, which restarts the max for a new pixel.
    always_comb begin
        max_d    = max_q;
        idx_d    = idx_q;
        cmp_base = (rd_bin_q == '0) ? '0 : max_q;
        if (rd_valid_q) begin
            if (rd_bin_q == '0) begin
                max_d = '0;
                idx_d = '0;
            end
            if (counts > cmp_base) begin
                max_d = counts;
                idx_d = rd_bin_q;
            end
        end
    end

    peak_finder_window #(
        .NB  (NB),
        .WIN (WIN)
    ) u_window (
        .bin      (idx_d),
        .th_minus (win_minus),
        .th_plus  (win_plus)
    );

    always_comb begin
        state_d      = state_q;
        pixel_d      = pixel_q;
        bin_d        = bin_q;
        rd_valid_d   = 1'b0;
        rd_bin_d     = bin_q;
        peak_pixel_d = peak_pixel_q;
        peak_bin_d   = peak_bin_q;
        peak_count_d = peak_count_q;
        th_minus_d   = th_minus_q;
        th_plus_d    = th_plus_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    pixel_d = '0;
                    bin_d   = '0;
                end
            end
            S_READ: begin
                rd_valid_d = 1'b1;
                bin_d      = bin_q + 1'b1;
                if (bin_q == LAST_BIN) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Final count arrives now; latch results so they hold until the next strobe.
                state_d      = S_EMIT;
                peak_pixel_d = pixel_q;
                peak_bin_d   = idx_d;
                peak_count_d = max_d;
                th_minus_d   = win_minus;
                th_plus_d    = win_plus;
            end
            S_EMIT: begin
                if (pixel_q == LAST_PIX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_READ;
                    pixel_d = pixel_q + 1'b1;
                    bin_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= S_IDLE;
            pixel_q      <= '0;
            bin_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_bin_q     <= '0;
            max_q        <= '0;
            idx_q        <= '0;
            peak_pixel_q <= '0;
            peak_bin_q   <= '0;
            peak_count_q <= '0;
            th_minus_q   <= '0;
            th_plus_q    <= '0;
        end else begin
            state_q      <= state_d;
            pixel_q      <= pixel_d;
            bin_q        <= bin_d;
            rd_valid_q   <= rd_valid_d;
            rd_bin_q     <= rd_bin_d;
            max_q        <= max_d;
            idx_q        <= idx_d;
            peak_pixel_q <= peak_pixel_d;
            peak_bin_q   <= peak_bin_d;
            peak_count_q <= peak_count_d;
            th_minus_q   <= th_minus_d;
            th_plus_q    <= th_plus_d;
        end
    end

    assign raddr      = {pixel_q, bin_q};
    assign rEnable    = (state_q != S_READ);
    assign readFlag   = (state_q == S_READ);
    assign busy       = (state_q != S_IDLE);
    assign peak_valid = (state_q == S_EMIT);
    assign done       = (state_q == S_DONE);
    assign peak_pixel = peak_pixel_q;
    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_count_q;
    assign th_minus   = th_minus_q;
    assign th_plus    = th_plus_q;

endmodule
